spi_master_68k: RTL
===================

Name: spi_master_68k

Overview:
- Byte-wide SPI master controller on the 68k I/O bus. It sits directly downstream of the SPI address decoder and responds when the decoder's enable is high, in the window 0x00408020–0x0040802F.
- Provides control, status, data, divider and chip-select registers, plus 4-deep transmit and receive FIFOs.
- Drives the SPI pins to the on-board flash and supplies an active-low interrupt to the 68k interrupt encoder.

Parameters:
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of two, minimum 2.
- CS_WIDTH, 8, number of chip-select outputs.

Ports:
- Clk  in  1  system clock
- Reset_L  in  1  asynchronous, active-low reset
- SPI_Enable_H  in  1  decoder enable; high for the whole addressed bus cycle, qualified by AS_L upstream
- WE_L  in  1  68k write enable; low means write
- Address  in  3  CPU Address[3:1]; selects the register
- DataIn  in  8  CPU write data from D[7:0]
- DataOut  out  8  register read data
- IRQ_L  out  1  interrupt request, active low
- SPI_SCLK  out  1  serial clock
- SPI_MOSI  out  1  serial data out
- SPI_MISO  in  1  serial data in
- SPI_CS_L  out  CS_WIDTH  chip selects, active low

Behaviour:
- Access strobe: a 1-cycle pulse on the rising edge of SPI_Enable_H, so each bus cycle produces exactly one write or one FIFO pop. DataOut is combinational from the register map while SPI_Enable_H is high, and 0x00 otherwise.
- Register map (Address[3:1]):
  - 0 CTRL, R/W: [7] IE, [6] EN, [3] CPOL, [2] CPHA; other bits read 0.
  - 1 STAT: [7] SPIF, [6] WCOL, [5] OVR, [3] TXFULL, [2] TXEMPTY, [1] RXFULL, [0] RXEMPTY. Bits 7..5 are cleared by writing 1. Writes to bits 3..0 are ignored.
  - 2 DATA: a write pushes to the TX FIFO; a read pops the RX FIFO.
  - 3 DIV, R/W: SCLK half-period = DIV+1 Clk cycles.
  - 4 CS, R/W: SPI_CS_L = ~CS.
  - 5–7: reserved; reads return 0x00, writes are ignored.
- Reset values:
  - CTRL=0x00, STAT=0x05, DIV=0x00, CS=0x00, both FIFOs empty.
  - SPI_SCLK=0, SPI_MOSI=1, SPI_CS_L all 1, IRQ_L=1, DataOut=0x00.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE→LOAD when EN=1 and the TX FIFO is not empty.
  - LOAD: pop TX into the shift register, load the half-period counter, clear the bit counter; SCLK=CPOL. If CPHA=0, MOSI = shift[7] this cycle.
  - SHIFT runs 16 half-periods, each DIV+1 cycles.
    - Leading edges sample MISO when CPHA=0 and drive MOSI when CPHA=1.
    - Trailing edges do the opposite.
    - MSB first.
  - DONE (1 cycle): push the received byte to RX, set SPIF, leave SCLK=CPOL. Then go to LOAD if TX is not empty, else IDLE.
- Throughput: a byte transfer takes 16*(DIV+1)+2 Clk cycles from LOAD entry to DONE exit.
- Boundary conditions:
  - DATA write with TX full: byte discarded, WCOL set.
  - DONE with RX full: received byte discarded, OVR set, SPIF still set.
  - DATA read with RX empty: returns 0x00, no pointer change.
  - TX push and pop in the same cycle: count unchanged, data ordering preserved.
  - EN cleared mid-transfer: FSM returns to IDLE on the next cycle, SCLK=CPOL, MOSI=1, both FIFOs flushed, status flags retained.
  - CPOL, CPHA and DIV writes during SHIFT take effect at the next LOAD; writing them mid-transfer is a software error.
  - Reset mid-transfer: everything immediately returns to the reset values above.
- Interrupt: IRQ_L = ~(IE & (SPIF | OVR)), registered.

Decomposition:
- Shared package holds:
  - register offset constants (REG_CTRL..REG_CS);
  - STAT bit index constants;
  - FSM state typedef.
- One sub-module: spi_byte_fifo (parameterised depth, push/pop/full/empty/count), instantiated twice for TX and RX.

Test Plan:
- Reset check: reset; read STAT → 0x05, CTRL → 0x00, SPI_CS_L=0xFF, IRQ_L=1.
- Mode 0 loopback (MISO tied to MOSI), DIV=1, CTRL=0x40:
  - write DATA=0xA5 → 8 SCLK periods of 4 Clk each;
  - MOSI bits 1,0,1,0,0,1,0,1;
  - SPIF set at 34 cycles after the push;
  - DATA read → 0xA5.
- Mode 3 with an external slave model returning 0x3C, CPOL=1 CPHA=1:
  - SCLK idles high;
  - RX reads 0x3C;
  - writing STAT=0x80 clears SPIF.
- FIFO limits:
  - write 6 bytes back-to-back with EN=0 → bytes 5 and 6 dropped, WCOL=1, TXFULL=1;
  - set EN → 4 transfers, no SCLK gap beyond DONE/LOAD.
  - Separately, 5 transfers without reading → OVR=1; first 4 RX bytes intact.
- Interrupt: IE=1, one transfer completes → IRQ_L=0; clear SPIF → IRQ_L=1 one cycle later.
- Abort: clear EN at bit 3 of 0xFF, then assert Reset_L low mid-transfer → SCLK returns to CPOL, FIFOs empty, STAT=0x05 after reset.

Source files
------------

// File: rtl/spi_master_68k_pkg.sv
// Shared definitions for the 68k SPI master: register offsets, bit positions, FSM states.
// Latency: none (constants only).
// Backpressure: not applicable.
package spi_master_68k_pkg;

  // Register offsets on CPU Address[3:1]
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd1;
  localparam logic [2:0] REG_DATA = 3'd2;
  localparam logic [2:0] REG_DIV  = 3'd3;
  localparam logic [2:0] REG_CS   = 3'd4;

  // CTRL bit positions
  localparam int CTRL_IE   = 7;
  localparam int CTRL_EN   = 6;
  localparam int CTRL_CPOL = 3;
  localparam int CTRL_CPHA = 2;

  // STAT bit positions
  localparam int STAT_SPIF    = 7;
  localparam int STAT_WCOL    = 6;
  localparam int STAT_OVR     = 5;
  localparam int STAT_TXFULL  = 3;
  localparam int STAT_TXEMPTY = 2;
  localparam int STAT_RXFULL  = 1;
  localparam int STAT_RXEMPTY = 0;

  // Transfer FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO with synchronous flush, used for both SPI TX and RX queues.
// Latency: a pushed byte is visible at rdata the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; caller checks full/empty.
module spi_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_master_68k.sv
// Byte-wide SPI master on the 68k I/O bus with 4-deep TX/RX FIFOs and active-low IRQ.
// Latency: one byte takes 16*(DIV+1)+2 Clk from LOAD entry to DONE exit; IRQ_L is registered.
// Backpressure: DATA write with TX full is dropped (WCOL); received byte with RX full is dropped (OVR).
module spi_master_68k
  import spi_master_68k_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CS_WIDTH   = 8
) (
  input  logic                Clk,
  input  logic                Reset_L,
  input  logic                SPI_Enable_H,
  input  logic                WE_L,
  input  logic [2:0]          Address,
  input  logic [7:0]          DataIn,
  output logic [7:0]          DataOut,
  output logic                IRQ_L,
  output logic                SPI_SCLK,
  output logic                SPI_MOSI,
  input  logic                SPI_MISO,
  output logic [CS_WIDTH-1:0] SPI_CS_L
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          en_q, strobe, wr, rd, wr_data, rd_data, wr_stat;
  logic          ctrl_ie, ctrl_en, ctrl_cpol, ctrl_cpha;
  logic [7:0]    div_reg;
  logic [CS_WIDTH-1:0] cs_reg;
  logic          spif, wcol, ovr, irq_l;
  logic [7:0]    rx_hold, rx_head, stat_vec;
  state_t        state;
  logic          cpol_q, cpha_q;
  logic [7:0]    div_q, hcnt, sr;
  logic [3:0]    ecnt;
  logic          sclk, mosi, abort, done_ok;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_full, rx_empty;
  logic [7:0]    tx_rdata, rx_rdata;
  logic [CW-1:0] tx_count, rx_count;

  assign strobe   = SPI_Enable_H & ~en_q;
  assign wr       = strobe & ~WE_L;
  assign rd       = strobe & WE_L;
  assign wr_data  = wr & (Address == REG_DATA);
  assign wr_stat  = wr & (Address == REG_STAT);
  assign rd_data  = rd & (Address == REG_DATA);
  assign abort    = ~ctrl_en & (state != ST_IDLE);
  assign done_ok  = (state == ST_DONE) & ~abort;
  assign tx_push  = wr_data & ~tx_full;
  assign tx_pop   = (state == ST_LOAD) & ~abort;
  assign rx_push  = done_ok & ~rx_full;
  assign rx_head  = rx_empty ? 8'h00 : rx_rdata;

  assign SPI_SCLK = sclk;
  assign SPI_MOSI = mosi;
  assign SPI_CS_L = ~cs_reg;
  assign IRQ_L    = irq_l;

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(Clk), .rst_n(Reset_L), .flush(abort),
    .push(tx_push), .wdata(DataIn), .pop(tx_pop), .rdata(tx_rdata),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(Clk), .rst_n(Reset_L), .flush(abort),
    .push(rx_push), .wdata(sr), .pop(rd_data), .rdata(rx_rdata),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Bus-side registers, sticky status flags (set beats write-1-clear) and registered IRQ
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      en_q      <= 1'b0;
      ctrl_ie   <= 1'b0;
      ctrl_en   <= 1'b0;
      ctrl_cpol <= 1'b0;
      ctrl_cpha <= 1'b0;
      div_reg   <= 8'h00;
      cs_reg    <= '0;
      spif      <= 1'b0;
      wcol      <= 1'b0;
      ovr       <= 1'b0;
      irq_l     <= 1'b1;
      rx_hold   <= 8'h00;
    end else begin
      en_q <= SPI_Enable_H;
      if (wr && Address == REG_CTRL) begin
        ctrl_ie   <= DataIn[CTRL_IE];
        ctrl_en   <= DataIn[CTRL_EN];
        ctrl_cpol <= DataIn[CTRL_CPOL];
        ctrl_cpha <= DataIn[CTRL_CPHA];
      end
      if (wr && Address == REG_DIV) div_reg <= DataIn;
      if (wr && Address == REG_CS)  cs_reg  <= DataIn[CS_WIDTH-1:0];
      spif  <= (spif & ~(wr_stat & DataIn[STAT_SPIF])) | done_ok;
      wcol  <= (wcol & ~(wr_stat & DataIn[STAT_WCOL])) | (wr_data & tx_full);
      ovr   <= (ovr  & ~(wr_stat & DataIn[STAT_OVR]))
               | (done_ok & (rx_count == CW'(FIFO_DEPTH)));
      irq_l <= ~(ctrl_ie & (spif | ovr));
      // Hold the popped byte so DataOut stays stable for the rest of the bus cycle
      if (rd_data) rx_hold <= rx_head;
    end
  end

  // Read mux: combinational while the decoder enable is high, zero otherwise
  always_comb begin
    stat_vec               = 8'h00;
    stat_vec[STAT_SPIF]    = spif;
    stat_vec[STAT_WCOL]    = wcol;
    stat_vec[STAT_OVR]     = ovr;
    stat_vec[STAT_TXFULL]  = tx_full;
    stat_vec[STAT_TXEMPTY] = tx_empty;
    stat_vec[STAT_RXFULL]  = rx_full;
    stat_vec[STAT_RXEMPTY] = rx_empty;
    DataOut = 8'h00;
    if (SPI_Enable_H) begin
      case (Address)
        REG_CTRL: DataOut = {ctrl_ie, ctrl_en, 2'b00, ctrl_cpol, ctrl_cpha, 2'b00};
        REG_STAT: DataOut = stat_vec;
        REG_DATA: DataOut = strobe ? rx_head : rx_hold;
        REG_DIV:  DataOut = div_reg;
        REG_CS:   DataOut = 8'(cs_reg);
        default:  DataOut = 8'h00;
      endcase
    end
  end

  // Transfer FSM: a single shift register both sends (MSB out) and receives (LSB in)
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state  <= ST_IDLE;
      sclk   <= 1'b0;
      mosi   <= 1'b1;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      div_q  <= 8'h00;
      hcnt   <= 8'h00;
      ecnt   <= 4'h0;
      sr     <= 8'h00;
    end else if (abort) begin
      state <= ST_IDLE;
      sclk  <= ctrl_cpol;
      mosi  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          sclk <= ctrl_cpol;
          mosi <= 1'b1;
          if (ctrl_en && tx_count != '0) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // Mode bits and divider are frozen here for the whole byte
          sr     <= tx_rdata;
          cpol_q <= ctrl_cpol;
          cpha_q <= ctrl_cpha;
          div_q  <= div_reg;
          hcnt   <= div_reg;
          ecnt   <= 4'h0;
          sclk   <= ctrl_cpol;
          mosi   <= ctrl_cpha ? 1'b1 : tx_rdata[7];
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (hcnt == 8'h00) begin
            hcnt <= div_q;
            sclk <= ~sclk;
            ecnt <= ecnt + 4'd1;
            // Even edges are leading; CPHA picks whether leading edges sample or drive
            if (~ecnt[0] ^ cpha_q) sr <= {sr[6:0], SPI_MISO};
            else                   mosi <= (ecnt == 4'd15) ? 1'b1 : sr[7];
            if (ecnt == 4'd15) state <= ST_DONE;
          end else begin
            hcnt <= hcnt - 8'd1;
          end
        end
        default: begin
          sclk  <= cpol_q;
          mosi  <= 1'b1;
          state <= (tx_count != '0) ? ST_LOAD : ST_IDLE;
        end
      endcase
    end
  end

endmodule
